bg_blitter: RTL and testbench
=============================

// Module: bg_blitter
// PURPOSE
//  Copies a stored image, one pixel per clock, from a synchronous colour ROM into the
//  vga_adapter framebuffer. It sweeps column/row counters, drives the ROM address, and
//  aligns x/y with the ROM read latency. Outputs are x, y, colour and plot.
//  It sits upstream of the vga_adapter and downstream of the screen ROMs (StartBG, game
//  BG). It feeds the top-level x/y/address/writeEn mux for each game screen.
// PARAMETERS
//  IMG_W     64       image width in pixels
//  IMG_H     64       image height in pixels (IMG_W*IMG_H <= 2**ADDR_W)
//  ADDR_W    12       ROM address width
//  ROM_LAT   2        ROM read latency in clocks: address in -> q valid (1..4)
//  SCR_W     160      screen width; pixels with x >= SCR_W are clipped
//  SCR_H     120      screen height; pixels with y >= SCR_H are clipped
//  KEY_COL   12'hF0F  transparent colour; never plotted when key_en=1
// PORTS
//  clk       in   1       system clock (CLOCK_50)
//  reset     in   1       asynchronous reset, active-high
//  start     in   1       request a blit; sampled only in IDLE
//  x0        in   8       top-left x of image; latched on accepted start
//  y0        in   8       top-left y of image; latched on accepted start
//  key_en    in   1       transparency enable; latched on accepted start
//  rom_addr  out  ADDR_W  ROM address = row*IMG_W + col
//  rom_q     in   12      ROM data, valid ROM_LAT clocks after rom_addr
//  x         out  8       framebuffer x of current pixel
//  y         out  8       framebuffer y of current pixel
//  colour    out  12      pixel colour (passes rom_q through combinationally)
//  plot      out  1       write strobe to the vga_adapter
//  busy      out  1       high from the accepted start until done
//  done      out  1       one-cycle pulse when the blit completes
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; col=row=0; rom_addr=0; x=y=0; plot=0;
//   busy=0; done=0; pipeline valid bits cleared. No residual plot after reset.
//  FSM: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
//   IDLE:  start=1 latches x0, y0 and key_en, sets busy=1, clears col/row, then -> RUN.
//   RUN:   drives rom_addr for (col,row) and pushes {valid,col,row} into a ROM_LAT-deep
//          shift pipe. col increments each cycle. At col=IMG_W-1, col wraps to 0 and
//          row increments. After issuing (IMG_W-1, IMG_H-1) -> FLUSH.
//   FLUSH: issues no new addresses and pushes valid=0. Stays ROM_LAT cycles to drain.
//   DONE:  done=1 and busy=0 for exactly one cycle, then -> IDLE.
//  Timing: start accepted at edge k. rom_addr=0 is presented in cycle k+1.
//   The first pixel appears in cycle k+1+ROM_LAT. Exactly IMG_W*IMG_H consecutive
//   pixel slots follow. done is high in the cycle after the last slot.
//  Pixel slot outputs, from pipe tail (col_d,row_d):
//   x = x0_l + col_d and y = y0_l + row_d, computed 9-bit.
//   plot = valid_d & (x<SCR_W) & (y<SCR_H) & ~(key_en_l & rom_q==KEY_COL).
//   x/y are driven to their 8-bit truncation even when the pixel is clipped.
//  rom_addr uses an incrementing counter, not a multiplier. It holds its last value
//   outside RUN.
//  start while busy (RUN/FLUSH/DONE) is ignored and not queued. start in the DONE cycle
//   is also ignored. start in IDLE the cycle after done is accepted.
//  x0/y0/key_en changes after acceptance have no effect on the current blit.
//  Cycle count for one blit, from accepted start to done: IMG_W*IMG_H + ROM_LAT + 1.
// TESTING (bench ROM model: q = addr[11:0] after ROM_LAT clocks)
//  1. IMG_W=4, IMG_H=2, ROM_LAT=2, x0=10, y0=20, start pulse at edge k ->
//     plot high cycles k+3..k+10. (x,y) runs (10,20)..(13,20),(10,21)..(13,21).
//     colour = 0..7. done high at k+11 only.
//  2. Clip: x0=158, y0=119, IMG_W=4, IMG_H=2 -> plot only for (158,119),(159,119).
//     done timing is unchanged from scenario 1.
//  3. Transparency: key_en=1 and ROM word 5 = 12'hF0F -> plot low in that slot only.
//     Repeat with key_en=0 -> 8 plots.
//  4. start held high for 20 cycles -> exactly one blit and one done pulse.
//     A second start the cycle after done -> second blit begins.
//  5. reset asserted mid-RUN (pixel 3) -> plot/busy drop asynchronously. After release
//     there is no plot until a new start, and the new blit starts at rom_addr=0.
//  6. Defaults (64x64, ROM_LAT=2) -> 4096 plots. Last rom_addr=4095.
//     done exactly 4099 cycles after start accepted.

Source files
------------

// File: rtl/bg_blitter.sv
// bg_blitter: sweeps an IMG_W x IMG_H image out of a synchronous colour ROM
// and emits one framebuffer pixel per clock, aligned to the ROM read latency.
module bg_blitter #(
  parameter int          IMG_W   = 64,
  parameter int          IMG_H   = 64,
  parameter int          ADDR_W  = 12,
  parameter int          ROM_LAT = 2,
  parameter int          SCR_W   = 160,
  parameter int          SCR_H   = 120,
  parameter logic [11:0] KEY_COL = 12'hF0F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        x0,
  input  logic [7:0]        y0,
  input  logic              key_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_q,
  output logic [7:0]        x,
  output logic [7:0]        y,
  output logic [11:0]       colour,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [2:0]    FL_LAST  = 3'(ROM_LAT - 1);
  localparam logic [8:0]    SW9      = 9'(SCR_W);
  localparam logic [8:0]    SH9      = 9'(SCR_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_x0;
  logic [7:0]        r_y0;
  logic              r_key;
  logic [2:0]        r_fcnt;

  logic [ROM_LAT-1:0] r_pv;
  logic [CW-1:0]      r_pc [ROM_LAT];
  logic [RW-1:0]      r_pr [ROM_LAT];

  logic       w_start_ok;
  logic       w_run;
  logic       w_last;
  logic [8:0] w_x9;
  logic [8:0] w_y9;
  logic       w_key_hit;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_run      = (r_state == S_RUN);
  assign w_last     = (r_col == COL_LAST) && (r_row == ROW_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FLUSH;
      S_FLUSH: if (r_fcnt == FL_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_RUN:   busy = 1'b1;
      S_FLUSH: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Address counter runs alongside col/row so no multiplier is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
      r_x0   <= '0;
      r_y0   <= '0;
      r_key  <= 1'b0;
      r_fcnt <= '0;
    end else begin
      if (w_start_ok) begin
        r_x0   <= x0;
        r_y0   <= y0;
        r_key  <= key_en;
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
      end else if (w_run && !w_last) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      r_fcnt <= (r_state == S_FLUSH) ? r_fcnt + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pc[i] <= '0;
        r_pr[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_run;
      r_pc[0] <= r_col;
      r_pr[0] <= r_row;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pc[i] <= r_pc[i-1];
        r_pr[i] <= r_pr[i-1];
      end
    end
  end

  assign w_x9      = {1'b0, r_x0} + 9'(r_pc[ROM_LAT-1]);
  assign w_y9      = {1'b0, r_y0} + 9'(r_pr[ROM_LAT-1]);
  assign w_key_hit = r_key && (rom_q == KEY_COL);

  assign rom_addr = r_addr;
  assign x        = w_x9[7:0];
  assign y        = w_y9[7:0];
  assign colour   = rom_q;
  assign plot     = r_pv[ROM_LAT-1] && (w_x9 < SW9) && (w_y9 < SH9) && !w_key_hit;

endmodule

// File: tb/tb_bg_blitter.sv
// tb_bg_blitter: scoreboard bench for bg_blitter, a 4x2 instance for the
// timing/clip/key/reset cases and a default 64x64 instance for the full sweep.
module tb_bg_blitter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   poke5 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int x;
    int y;
    int col;
  } px_t;

  px_t pq[$];
  int  dq[$];
  px_t bq[$];

  logic        s_start, s_key, s_plot, s_busy, s_done;
  logic [7:0]  s_x0, s_y0, s_x, s_y;
  logic [11:0] s_addr, s_q, s_col, s_r1, s_r2;

  logic        b_start, b_key, b_plot, b_busy, b_done;
  logic [7:0]  b_x0, b_y0, b_x, b_y;
  logic [11:0] b_addr, b_q, b_col, b_r1, b_r2;

  int b_nplot = 0;
  int b_ndone = 0;
  int b_done_cyc = -1;

  bg_blitter #(.IMG_W(4), .IMG_H(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start),
    .x0(s_x0), .y0(s_y0), .key_en(s_key),
    .rom_addr(s_addr), .rom_q(s_q),
    .x(s_x), .y(s_y), .colour(s_col),
    .plot(s_plot), .busy(s_busy), .done(s_done)
  );

  bg_blitter u_big (
    .clk(clk), .reset(reset), .start(b_start),
    .x0(b_x0), .y0(b_y0), .key_en(b_key),
    .rom_addr(b_addr), .rom_q(b_q),
    .x(b_x), .y(b_y), .colour(b_col),
    .plot(b_plot), .busy(b_busy), .done(b_done)
  );

  // two-clock synchronous ROMs holding q = addr, word 5 optionally keyed
  always @(posedge clk) begin
    s_r1 <= (poke5 && s_addr == 12'd5) ? 12'hF0F : s_addr;
    s_r2 <= s_r1;
    b_r1 <= b_addr;
    b_r2 <= b_r1;
  end
  assign s_q = s_r2;
  assign b_q = b_r2;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    px_t e;
    if (!reset) begin
      if (s_plot) begin
        if (pq.size() == 0) chk("s_plot_unexp", 32'(s_plot), 0);
        else begin
          e = pq.pop_front();
          chk("s_px_cyc", cyc, e.c);
          chk("s_px_x", 32'(s_x), e.x);
          chk("s_px_y", 32'(s_y), e.y);
          chk("s_px_col", 32'(s_col), e.col);
        end
      end
      if (s_done) begin
        if (dq.size() == 0) chk("s_done_unexp", 32'(s_done), 0);
        else chk("s_done_cyc", cyc, dq.pop_front());
      end
      if (b_plot) begin
        b_nplot++;
        if (bq.size() == 0) chk("b_plot_unexp", 32'(b_plot), 0);
        else begin
          e = bq.pop_front();
          chk("b_px_cyc", cyc, e.c);
          chk("b_px_x", 32'(b_x), e.x);
          chk("b_px_y", 32'(b_y), e.y);
          chk("b_px_col", 32'(b_col), e.col);
        end
      end
      if (b_done) begin
        b_ndone++;
        b_done_cyc = cyc;
      end
    end
  end

  // m = cycle count at the negedge where start is driven
  task automatic push_blit(input int m, input int x0, input int y0, input bit key);
    for (int i = 0; i < 8; i++) begin
      int xx, yy, cc;
      xx = x0 + i % 4;
      yy = y0 + i / 4;
      cc = (poke5 && i == 5) ? 'hF0F : i;
      if (xx < 160 && yy < 120 && !(key && cc == 'hF0F))
        pq.push_back('{m + 3 + i, xx & 255, yy & 255, cc});
    end
    dq.push_back(m + 11);
  endtask

  task automatic blit(input int x0, input int y0, input bit key);
    @(negedge clk);
    s_x0 = 8'(x0);
    s_y0 = 8'(y0);
    s_key = key;
    s_start = 1'b1;
    push_blit(cyc, x0, y0, key);
    @(negedge clk);
    s_start = 1'b0;
    s_x0 = 8'($urandom_range(0, 255));
    s_y0 = 8'($urandom_range(0, 255));
    s_key = ~key;
    chk("busy_on", 32'(s_busy), 1);
    chk("addr0", 32'(s_addr), 0);
    repeat (14) @(negedge clk);
    chk("pq_empty", pq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    chk("idle_busy", 32'(s_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int m;
    s_start = 0; s_x0 = 0; s_y0 = 0; s_key = 0;
    b_start = 0; b_x0 = 0; b_y0 = 0; b_key = 0;
    #1 reset = 1'b1;
    #1;
    chk("rst_plot", 32'(s_plot), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_done", 32'(s_done), 0);
    chk("rst_addr", 32'(s_addr), 0);
    chk("rst_x", 32'(s_x), 0);
    chk("rst_y", 32'(s_y), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    blit(10, 20, 0);
    blit(158, 119, 0);
    poke5 = 1'b1;
    blit(10, 20, 1);
    blit(10, 20, 0);
    poke5 = 1'b0;

    // start held across the whole blit: ignored while busy and in DONE,
    // taken again in the IDLE cycle right after done
    @(negedge clk);
    m = cyc;
    s_x0 = 8'd30; s_y0 = 8'd40; s_key = 0; s_start = 1'b1;
    push_blit(m, 30, 40, 0);
    push_blit(m + 12, 30, 40, 0);
    repeat (13) @(negedge clk);
    s_start = 1'b0;
    repeat (16) @(negedge clk);
    chk("b2b_pq_empty", pq.size(), 0);
    chk("b2b_dq_empty", dq.size(), 0);
    chk("b2b_busy", 32'(s_busy), 0);

    @(negedge clk);
    m = cyc;
    s_x0 = 8'd10; s_y0 = 8'd20; s_key = 0; s_start = 1'b1;
    push_blit(m, 10, 20, 0);
    @(negedge clk);
    s_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_plot", 32'(s_plot), 1);
    #2;
    pq.delete();
    dq.delete();
    reset = 1'b1;
    #1;
    chk("arst_plot", 32'(s_plot), 0);
    chk("arst_busy", 32'(s_busy), 0);
    chk("arst_addr", 32'(s_addr), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", 32'(s_busy), 0);
    blit(0, 0, 0);

    @(negedge clk);
    m = cyc;
    b_x0 = 8'd50; b_y0 = 8'd40; b_key = 0; b_start = 1'b1;
    for (int i = 0; i < 4096; i++)
      bq.push_back('{m + 3 + i, 50 + i % 64, 40 + i / 64, i});
    repeat (20) @(negedge clk);
    b_start = 1'b0;
    repeat (4100) @(negedge clk);
    chk("big_bq_empty", bq.size(), 0);
    chk("big_nplot", b_nplot, 4096);
    chk("big_ndone", b_ndone, 1);
    chk("big_done_cyc", b_done_cyc, m + 4099);
    chk("big_last_addr", 32'(b_addr), 4095);
    chk("big_busy", 32'(b_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
